// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared FSM state encoding for the bit-serial adder controller
package serial_add_pkg;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_CALC = 2'd1;
  localparam logic [1:0] ENC_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_CALC = ENC_CALC,
    ST_DONE = ENC_DONE
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - gate-level 1-bit full adder used as the serial datapath
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - LSB-first bit-serial adder with valid/ready handshakes
// Optional signed-overflow output ovf is built when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             busy,
  output logic             ovf
`else
  output logic             busy
`endif
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_acc_next;

  fa_cell u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
  assign w_acc_next = {w_s, {(WIDTH-1){1'b0}}} | (r_acc >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            r_a      <= a;
            r_b      <= b;
            r_carry  <= cin;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_acc   <= w_acc_next;
          r_cnt   <= r_cnt + CW'(1);
          // Visible outputs only change here, so they keep the previous result during CALC.
          if (r_cnt == LAST_BIT) begin
            sum       <= w_acc_next;
            cout      <= w_c;
            out_valid <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= r_carry ^ w_c;
`endif
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_checks;
  int n_fail;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SERIAL_ADD_OVF_EN
    .busy      (busy),
    .ovf       (ovf)
`else
    .busy      (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction: offer operands, measure latency, hold result for 'hold' cycles, then retire.
  task automatic run(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                     input logic tc, input logic [W-1:0] es, input logic ec, input logic eo,
                     input int hold, input bit noise);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    cin       = tc;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (noise) begin
        in_valid = ~in_valid;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = ~cin;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, lat, W);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("unused overflow expectation");
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_sum"}, sum, es);
      check({tag, "_hold_cout"}, cout, ec);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, out_valid, 0);
    check({tag, "_idle_in_ready"}, in_ready, 1);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_kept_sum"}, sum, es);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);

    run("basic",   8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0, 1'b0);
    run("wrap1",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    run("wrapcin", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    run("hold",    8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 5, 1'b0);
    run("carry",   8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0, 0, 1'b0);

    // Reset while bit 3 is next to be processed; the previous result (0x2C) must be cleared.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'hA5;
    b        = 8'h0F;
    cin      = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    run("afterrst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1'b0);

    run("noise",   8'h9B, 8'h47, 1'b0, 8'hE2, 1'b0, 1'b0, 2, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("noise_single_txn", out_valid, 0);
    end

`ifdef SERIAL_ADD_OVF_EN
    run("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b0);
    run("ovf_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
